// File: rtl/ping_pong_drain_ctrl.sv
// ping_pong_drain_ctrl
//   Output-side ping-pong buffer for the attention datapath. Result words
//   from the accumulator wrapper fill one bank while the other bank drains
//   to the downstream consumer. The producer is stalled when both banks hold
//   undrained data. A flush closes a partially filled bank early.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   in_valid/in_data    producer word stream, accepted when in_ready=1
//   in_ready            write bank is free
//   flush               close the partially filled write bank
//   out_valid/out_data  word from the current read bank (0 when idle)
//   out_last            final word of the bank being drained
//   out_ready           consumer accepts the presented word
//   bank_valid[1:0]     per-bank "holds undrained data" flags
//   drain_idle          both banks empty and no partial fill in progress
module ping_pong_drain_ctrl #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4,
   parameter int LEN_WIDTH  = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   input  logic                  flush,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic [1:0]            bank_valid,
   output logic                  drain_idle
);

   localparam int AW = $clog2(DEPTH);

   // Observable occupancy state, tracked alongside the datapath registers.
   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_FILL_DRAIN,
      S_FULL
   } state_t;

   logic [DATA_WIDTH-1:0]       mem [2][DEPTH];
   logic                        wr_sel, rd_sel;
   logic [AW-1:0]               wr_addr, rd_addr;
   logic [1:0][LEN_WIDTH-1:0]   len;
   state_t                      state;

   logic                        wr_sel_nxt, rd_sel_nxt;
   logic [AW-1:0]               wr_addr_nxt, rd_addr_nxt;
   logic [1:0][LEN_WIDTH-1:0]   len_nxt;
   logic [1:0]                  bank_valid_nxt;
   state_t                      state_nxt;

   logic                        wr_acc, rd_acc;
   logic                        close_full, close_flush, close;
   logic [LEN_WIDTH-1:0]        wr_addr_eff, close_len;

   assign in_ready   = ~bank_valid[wr_sel];
   assign out_valid  = bank_valid[rd_sel];
   assign out_data   = out_valid ? mem[rd_sel][rd_addr] : '0;
   assign out_last   = out_valid &
                       (LEN_WIDTH'(rd_addr) == len[rd_sel] - LEN_WIDTH'(1));
   assign drain_idle = (state == S_IDLE);

   assign wr_acc = in_valid & in_ready;
   assign rd_acc = out_valid & out_ready;

   // A word landing in the last slot closes the bank on its own; a flush in
   // that same cycle must not close the (fresh, empty) next bank as well.
   assign wr_addr_eff = LEN_WIDTH'(wr_addr) + LEN_WIDTH'(wr_acc);
   assign close_full  = wr_acc & (wr_addr == AW'(DEPTH - 1));
   assign close_flush = flush & in_ready & (wr_addr_eff != '0) & ~close_full;
   assign close       = close_full | close_flush;
   assign close_len   = close_full ? LEN_WIDTH'(DEPTH) : wr_addr_eff;

   always_comb begin
      wr_sel_nxt     = wr_sel;
      wr_addr_nxt    = wr_addr;
      rd_sel_nxt     = rd_sel;
      rd_addr_nxt    = rd_addr;
      len_nxt        = len;
      bank_valid_nxt = bank_valid;
      state_nxt      = state;

      if (close) begin
         len_nxt[wr_sel]        = close_len;
         bank_valid_nxt[wr_sel] = 1'b1;
         wr_sel_nxt             = ~wr_sel;
         wr_addr_nxt            = '0;
      end else if (wr_acc) begin
         wr_addr_nxt = wr_addr + AW'(1);
      end

      // Write bank is never valid and read bank always is, so the close above
      // and the drain-complete below always touch different banks.
      if (rd_acc) begin
         if (out_last) begin
            bank_valid_nxt[rd_sel] = 1'b0;
            rd_sel_nxt             = ~rd_sel;
            rd_addr_nxt            = '0;
         end else begin
            rd_addr_nxt = rd_addr + AW'(1);
         end
      end

      case (bank_valid_nxt)
         2'b00:   state_nxt = (wr_addr_nxt == '0) ? S_IDLE : S_FILL;
         2'b11:   state_nxt = S_FULL;
         default: state_nxt = S_FILL_DRAIN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_sel     <= 1'b0;
         rd_sel     <= 1'b0;
         wr_addr    <= '0;
         rd_addr    <= '0;
         len        <= '0;
         bank_valid <= 2'b00;
         state      <= S_IDLE;
      end else begin
         wr_sel     <= wr_sel_nxt;
         rd_sel     <= rd_sel_nxt;
         wr_addr    <= wr_addr_nxt;
         rd_addr    <= rd_addr_nxt;
         len        <= len_nxt;
         bank_valid <= bank_valid_nxt;
         state      <= state_nxt;
      end
   end

   // Storage needs no reset: out_data is masked until a bank is closed.
   always_ff @(posedge clk) begin
      if (rst_n && wr_acc) mem[wr_sel][wr_addr] <= in_data;
   end

endmodule

// File: tb/tb_ping_pong_drain_ctrl.sv
// tb_ping_pong_drain_ctrl
//   Directed bench for ping_pong_drain_ctrl (DATA_WIDTH=64, DEPTH=4).
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   in the same window, before the next edge.
module tb_ping_pong_drain_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_ready;
   logic        flush;
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_last;
   logic        out_ready;
   logic [1:0]  bank_valid;
   logic        drain_idle;

   int total = 0;
   int bad   = 0;

   ping_pong_drain_ctrl #(.DATA_WIDTH(64), .DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .bank_valid (bank_valid),
      .drain_idle (drain_idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one word for a single cycle; it must be accepted.
   task automatic push(input logic [63:0] d, input logic fl);
      in_valid = 1'b1;
      in_data  = d;
      flush    = fl;
      chk("push_rdy", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   // Drain one word with out_ready=1 and check it.
   task automatic pop(input logic [63:0] d, input logic last);
      out_ready = 1'b1;
      chk("pop_vld", out_valid, 1'b1);
      chk("pop_data", out_data, d);
      chk("pop_last", out_last, last);
      tick();
   endtask

   initial begin
      int ni, no;
      logic hold_v, acc_i, acc_o;
      logic [63:0] hold;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;

      // reset state
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_idle", drain_idle, 1'b1);
      chk("rst_bv", bank_valid, 2'b00);

      // basic fill/drain: bank0, visible the cycle after the 4th accept
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk("basic_nov", out_valid, 1'b0);
         push(64'(k), 1'b0);
      end
      chk("basic_bv", bank_valid, 2'b01);
      chk("basic_first", out_data, 64'd1);
      for (int k = 1; k <= 4; k++) pop(64'(k), k == 4);
      chk("basic_bv_end", bank_valid, 2'b00);
      chk("basic_idle", drain_idle, 1'b1);
      // now wr_sel=1, rd_sel=1

      // back-pressure: fill bank1 (1..4) and bank0 (5..8)
      out_ready = 1'b0;
      for (int k = 1; k <= 8; k++) push(64'(k), 1'b0);
      chk("bp_bv", bank_valid, 2'b11);
      chk("bp_stall", in_ready, 1'b0);
      in_valid = 1'b1; in_data = 64'd9;
      tick();
      chk("bp_stall2", in_ready, 1'b0);
      chk("bp_hold", out_data, 64'd1);
      out_ready = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         chk("bp_vld", out_valid, 1'b1);
         chk("bp_data", out_data, 64'(j));
         chk("bp_last", out_last, (j == 4) || (j == 8));
         if (j <= 5) chk("bp_rdy", in_ready, j == 5);
         tick();
         if (j == 5) in_valid = 1'b0;  // word 9 taken at that edge
      end
      // word 9 sits in a partial bank: not idle, nothing to drain
      chk("bp_bv_end", bank_valid, 2'b00);
      chk("bp_partial", drain_idle, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("bp_fl_bv", bank_valid, 2'b10);
      pop(64'd9, 1'b1);
      chk("bp_idle", drain_idle, 1'b1);
      // now wr_sel=0, rd_sel=0

      // overlap: 1..12 continuous, out_ready toggling
      ni = 1; no = 1; hold_v = 1'b0; hold = '0;
      for (int c = 0; c < 200 && no <= 12; c++) begin
         in_valid  = (ni <= 12);
         in_data   = 64'(ni);
         out_ready = (c % 2 == 0);
         if (hold_v) begin
            chk("ovl_hold_v", out_valid, 1'b1);
            chk("ovl_hold_d", out_data, hold);
         end
         if (out_valid) begin
            chk("ovl_data", out_data, 64'(no));
            chk("ovl_last", out_last, (no % 4) == 0);
         end
         hold_v = out_valid & ~out_ready;
         hold   = out_data;
         acc_i  = in_valid & in_ready;
         acc_o  = out_valid & out_ready;
         tick();
         if (acc_i) ni++;
         if (acc_o) no++;
      end
      in_valid = 1'b0;
      chk("ovl_count", 64'(no), 64'd13);
      chk("ovl_idle", drain_idle, 1'b1);
      // 3 banks each side: wr_sel=1, rd_sel=1

      // flush alone closes a length-2 bank
      out_ready = 1'b1;
      push(64'd10, 1'b0);
      push(64'd11, 1'b0);
      chk("fl_nov", out_valid, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_bv", bank_valid, 2'b10);
      pop(64'd10, 1'b0);
      pop(64'd11, 1'b1);
      chk("fl_bv_end", bank_valid, 2'b00);
      // flush with nothing written is ignored
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_empty_bv", bank_valid, 2'b00);
      chk("fl_empty_idle", drain_idle, 1'b1);
      chk("fl_empty_nov", out_valid, 1'b0);
      // now wr_sel=0, rd_sel=0

      // flush together with the 2nd word
      push(64'd20, 1'b0);
      push(64'd21, 1'b1);
      chk("flw_bv", bank_valid, 2'b01);
      pop(64'd20, 1'b0);
      pop(64'd21, 1'b1);
      // flush together with the 4th word: one length-4 bank only (bank1)
      out_ready = 1'b0;
      push(64'd30, 1'b0);
      push(64'd31, 1'b0);
      push(64'd32, 1'b0);
      push(64'd33, 1'b1);
      chk("fl4_bv", bank_valid, 2'b10);
      pop(64'd30, 1'b0);
      pop(64'd31, 1'b0);
      pop(64'd32, 1'b0);
      pop(64'd33, 1'b1);
      chk("fl4_idle", drain_idle, 1'b1);

      // reset mid-operation; wr_sel must be back on bank0
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) push(64'(40 + k), 1'b0);
      chk("rm_bv1", bank_valid, 2'b01);
      for (int k = 4; k < 8; k++) push(64'(40 + k), 1'b0);
      chk("rm_bv2", bank_valid, 2'b11);
      rst_n = 1'b0; in_valid = 1'b1; in_data = 64'd99;
      tick();
      rst_n = 1'b1; in_valid = 1'b0;
      chk("rm_bv", bank_valid, 2'b00);
      chk("rm_nov", out_valid, 1'b0);
      chk("rm_rdy", in_ready, 1'b1);
      chk("rm_idle", drain_idle, 1'b1);
      chk("rm_data", out_data, 64'd0);
      for (int k = 0; k < 4; k++) push(64'(50 + k), 1'b0);
      chk("rm_new_bv", bank_valid, 2'b01);
      for (int k = 0; k < 4; k++) pop(64'(50 + k), k == 3);
      chk("rm_end_bv", bank_valid, 2'b00);
      chk("rm_end_nov", out_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ping_pong_drain_ctrl.md
Name: ping_pong_drain_ctrl

Overview:
- Output-side counterpart of the input ping-pong control for the multi-head attention datapath.
- Collects result words produced by the systolic/accumulator wrapper into one of two internal banks while the other bank drains to the downstream consumer over a valid/ready stream.
- Back-pressures the producer when both banks hold undrained data.
- Supports an early flush that closes a partially filled bank.

Parameters:
- DATA_WIDTH, 64, width of one result word.
- DEPTH, 4, words per bank (full-bank length); must be >= 2.
- LEN_WIDTH, $clog2(DEPTH)+1, width of the stored per-bank length.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  producer word valid.
- in_data  input  DATA_WIDTH  producer word.
- in_ready  output  1  block can accept a word this cycle.
- flush  input  1  close the current partially filled write bank.
- out_valid  output  1  out_data is valid.
- out_data  output  DATA_WIDTH  word from the current read bank.
- out_last  output  1  out_data is the final word of its bank.
- out_ready  input  1  consumer accepts the word.
- bank_valid  output  2  per-bank "holds undrained data" flags.
- drain_idle  output  1  both banks empty and no partial fill in progress.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- State: wr_sel, wr_addr, rd_sel, rd_addr, bank_valid[1:0], and len[b] per bank.
- Reset (rst_n=0 at an edge):
  - wr_sel=0, rd_sel=0, wr_addr=0, rd_addr=0, bank_valid=00, len=0.
  - Inputs sampled during reset are ignored.
  - Post-reset outputs: in_ready=1, out_valid=0, out_last=0, out_data=0, drain_idle=1.
- Derived outputs:
  - in_ready = ~bank_valid[wr_sel].
  - out_valid = bank_valid[rd_sel].
  - out_data = bank[rd_sel][rd_addr] (combinational read of registered storage); forced to 0 when out_valid=0.
  - out_last = out_valid & (rd_addr == len[rd_sel]-1).
  - drain_idle = (bank_valid==00) & (wr_addr==0).
- Write accept (in_valid & in_ready):
  - Store in_data at bank[wr_sel][wr_addr].
  - If wr_addr==DEPTH-1: len[wr_sel]=DEPTH, bank_valid[wr_sel]=1, wr_sel toggles, wr_addr=0.
  - Otherwise wr_addr++.
- Flush (flush & in_ready & wr_addr_eff>0):
  - wr_addr_eff = wr_addr + (write accepted this cycle).
  - If the same-cycle write already completed the bank, flush has no further effect.
  - Otherwise: len[wr_sel]=wr_addr_eff, bank_valid[wr_sel]=1, wr_sel toggles, wr_addr=0.
  - Flush with wr_addr_eff==0, or with in_ready=0, is ignored (not latched).
- Read accept (out_valid & out_ready):
  - If out_last: bank_valid[rd_sel]=0, rd_sel toggles, rd_addr=0.
  - Otherwise rd_addr++.
  - out_data/out_valid must stay stable while out_valid=1 and out_ready=0.
- Latency: a word written in the cycle that closes a bank is presentable on out_valid the next cycle, provided rd_sel points to that bank.
- Simultaneous close of one bank and drain-complete of the other in the same cycle: both updates apply. The same bank cannot be both written and read.
- Observable FSM, derived from bank_valid and wr_addr:
  - S_IDLE: bank_valid=00, wr_addr=0.
  - S_FILL: no bank valid, wr_addr>0.
  - S_FILL_DRAIN: exactly one bank valid.
  - S_FULL: bank_valid=11; in_ready=0, writes stall.
  - Transitions: S_IDLE->S_FILL on the first accepted word; S_FILL->S_FILL_DRAIN on bank close; S_FILL_DRAIN->S_FULL on close with no drain completing; S_FULL->S_FILL_DRAIN on drain complete; S_FILL_DRAIN->S_FILL or S_IDLE when the last valid bank drains.
- Ordering: banks drain strictly in close order; words within a bank drain in write order.
- Reset mid-operation: all contents are discarded and the block returns to the reset state next cycle; no out_valid after reset until a new bank closes.

Test Plan:
- Basic fill/drain (DEPTH=4):
  - Stimulus: push 1,2,3,4 with out_ready=1.
  - Response: cycle after the 4th accept, out_valid=1 with 1; stream 1,2,3,4; out_last only on 4; bank_valid returns 00; drain_idle=1.
- Back-pressure:
  - Stimulus: out_ready=0; push 8 words (1..8); offer a 9th.
  - Response: bank_valid=11, in_ready=0, 9th not accepted.
  - Then out_ready=1: out stream 1..8 with out_last on 4 and 8; in_ready=1 again after word 4 drains; 9th accepted.
- Overlap:
  - Stimulus: continuous input 1..12, out_ready toggling 1,0,1,0.
  - Response: output order exactly 1..12; no drop or duplicate; out_data stable while out_ready=0.
- Flush:
  - Stimulus: push 10,11; assert flush alone.
  - Response: bank closes with len=2; output 10,11 with out_last on 11.
  - Then flush with wr_addr=0 and no write: no bank_valid change.
- Flush with write:
  - Stimulus: push 20; then 21 with flush in the same cycle.
  - Response: len=2; output 20,21, out_last on 21.
  - Also: a flush coinciding with the 4th word closes a length-4 bank only; wr_sel advances once.
- Reset mid-operation:
  - Stimulus: with bank_valid=11, pulse rst_n=0 for 1 cycle.
  - Response: next cycle bank_valid=00, out_valid=0, in_ready=1, drain_idle=1; a new 4-word push drains only the new words.
